// File: rtl/fifo_ctrl_8x32_pkg.sv
// Shared sizing and types for the router input-port FIFO controller.
// Holds the default flit/address widths, RAM depth and counter widths.
package fifo_ctrl_8x32_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_RAM_SIZE   = 8;
  localparam int FIFO_CNT_WIDTH = 4;
  localparam int OB_CNT_WIDTH   = 2;

  typedef logic [OB_CNT_WIDTH-1:0] ob_cnt_t;

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer (head + skid) behind the registered RAM read.
// Ports: cap_en/cap_data capture, pop removes head, out_valid/out_data, ob_cnt.
module fifo_out_skid
  import fifo_ctrl_8x32_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_en,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output ob_cnt_t               ob_cnt
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] head_d;
  logic [DATA_WIDTH-1:0] skid_d;
  ob_cnt_t               cnt_d;
  ob_cnt_t               rem;

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    rem    = ob_cnt - ob_cnt_t'(pop);
    cnt_d  = ob_cnt + ob_cnt_t'(cap_en) - ob_cnt_t'(pop);
    if (pop && ob_cnt == 2'd2) begin
      head_d = skid_q;
    end
    // Land in the head only if the buffer is empty once this pop is done.
    if (cap_en) begin
      unique case (1'b1)
        (rem == '0): head_d = cap_data;
        default:     skid_d = cap_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
      ob_cnt <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      ob_cnt <= cnt_d;
    end
  end

  assign out_valid = (ob_cnt != '0);
  assign out_data  = head_q;

endmodule

// File: rtl/fifo_ctrl_8x32.sv
// FIFO controller in front of ram_8x32: pointers, occupancy, RAM strobes.
// Ports: in_* / out_* valid-ready streams, ram_* to the RAM, fifo_cnt total.
module fifo_ctrl_8x32
  import fifo_ctrl_8x32_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RAM_SIZE   = DEF_RAM_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      ram_wr_en,
  output logic [ADDR_WIDTH-1:0]     ram_wr_addr,
  output logic [DATA_WIDTH-1:0]     ram_wr_data,
  output logic                      ram_rd_en,
  output logic [ADDR_WIDTH-1:0]     ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]     ram_rd_data,
  output logic [FIFO_CNT_WIDTH-1:0] fifo_cnt
);

  localparam logic [FIFO_CNT_WIDTH-1:0] RAM_FULL =
    FIFO_CNT_WIDTH'(RAM_SIZE);

  logic [ADDR_WIDTH-1:0]     wr_ptr;
  logic [ADDR_WIDTH-1:0]     rd_ptr;
  logic [FIFO_CNT_WIDTH-1:0] ram_cnt;
  logic                      rd_pend;
  logic                      pop;
  ob_cnt_t                   ob_cnt;
  logic [OB_CNT_WIDTH:0]     ob_after;

  assign in_ready    = (ram_cnt != RAM_FULL);
  assign ram_wr_en   = in_valid & in_ready;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = in_data;

  assign pop = out_valid & out_ready;

  // Buffer occupancy once this cycle's capture and pop settle; a new
  // read is only issued if its data is sure to find a free slot.
  assign ob_after = {1'b0, ob_cnt}
                  + (OB_CNT_WIDTH+1)'(rd_pend)
                  - (OB_CNT_WIDTH+1)'(pop);

  assign ram_rd_en   = (ram_cnt != '0) & (ob_after < 3'd2);
  assign ram_rd_addr = rd_ptr;

  assign fifo_cnt = ram_cnt
                  + FIFO_CNT_WIDTH'(rd_pend)
                  + FIFO_CNT_WIDTH'(ob_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (ram_wr_en) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (ram_rd_en) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      ram_cnt <= ram_cnt
               + FIFO_CNT_WIDTH'(ram_wr_en)
               - FIFO_CNT_WIDTH'(ram_rd_en);
      rd_pend <= ram_rd_en;
    end
  end

  fifo_out_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_en   (rd_pend),
    .cap_data (ram_rd_data),
    .pop      (pop),
    .out_valid(out_valid),
    .out_data (out_data),
    .ob_cnt   (ob_cnt)
  );

endmodule

// File: tb/tb_fifo_ctrl_8x32.sv
// Directed bench for fifo_ctrl_8x32 with a behavioural ram_8x32 model.
// Each scenario task drives stimulus and checks its own expectations.
module tb_fifo_ctrl_8x32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        ram_wr_en;
  logic [2:0]  ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic        ram_rd_en;
  logic [2:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic [3:0]  fifo_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [8];

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      ram_rd_data <= '0;
    end else begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= ram_rd_en ? mem[ram_rd_addr] : '0;
    end
  end

  fifo_ctrl_8x32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .fifo_cnt   (fifo_cnt)
  );

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    nxt();
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    tests++;
    if (out_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_out_data got %h want 0", out_data);
    end
    tests++;
    if (fifo_cnt !== 4'd0) begin
      fails++;
      $display("FAIL reset_fifo_cnt got %0d want 0", fifo_cnt);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    tests++;
    if (ram_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_ram_rd_en got %b want 0", ram_rd_en);
    end
    nxt();
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k);
      #2;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL fill_accept_%0d got in_ready %b want 1", k, in_ready);
      end
      nxt();
    end
    in_data = 32'hFF;
    #2;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_full_in_ready got %b want 0", in_ready);
    end
    tests++;
    if (ram_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL fill_full_wr_en got %b want 0", ram_wr_en);
    end
    tests++;
    if (fifo_cnt !== 4'd10) begin
      fails++;
      $display("FAIL fill_fifo_cnt got %0d want 10", fifo_cnt);
    end
    tests++;
    if ({out_valid, out_data} !== {1'b1, 32'h1}) begin
      fails++;
      $display("FAIL fill_head got %b/%h want 1/1", out_valid, out_data);
    end
    nxt();
    #2;
    tests++;
    if ({out_valid, out_data} !== {1'b1, 32'h1}) begin
      fails++;
      $display("FAIL fill_head_hold got %b/%h want 1/1", out_valid, out_data);
    end
    tests++;
    if (fifo_cnt !== 4'd10) begin
      fails++;
      $display("FAIL fill_fifo_cnt_hold got %0d want 10", fifo_cnt);
    end
    in_valid = 1'b0;
    nxt();
  endtask

  task automatic test_drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      #2;
      tests++;
      if ({out_valid, out_data} !== {1'b1, 32'(k)}) begin
        fails++;
        $display("FAIL drain_%0d got %b/%h want 1/%h",
                 k, out_valid, out_data, k);
      end
      if (k == 2) begin
        tests++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL drain_in_ready_rise got %b want 1", in_ready);
        end
      end
      nxt();
    end
    #2;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty_valid got %b want 0", out_valid);
    end
    tests++;
    if (fifo_cnt !== 4'd0) begin
      fails++;
      $display("FAIL drain_empty_cnt got %0d want 0", fifo_cnt);
    end
    out_ready = 1'b0;
    nxt();
  endtask

  task automatic test_stream();
    logic [31:0] q[$];
    logic [31:0] exp;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int first_acc = -1;
    int first_val = -1;
    int last_pop = -1;
    out_ready = 1'b1;
    while (got < 20 && cyc < 200) begin
      in_valid = (sent < 20);
      in_data  = 32'h100 + 32'(sent);
      #2;
      if (out_valid) begin
        if (first_val < 0) first_val = cyc;
        exp = (q.size() > 0) ? q.pop_front() : 32'hBAD0BAD0;
        tests++;
        if (out_data !== exp) begin
          fails++;
          $display("FAIL stream_data got %h want %h", out_data, exp);
        end
        got++;
        last_pop = cyc;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      nxt();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (got != 20) begin
      fails++;
      $display("FAIL stream_count got %0d want 20", got);
    end
    tests++;
    if (first_val - first_acc != 3) begin
      fails++;
      $display("FAIL stream_latency got %0d want 3", first_val - first_acc);
    end
    tests++;
    if (last_pop - first_val != 19) begin
      fails++;
      $display("FAIL stream_rate got %0d want 19", last_pop - first_val);
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] exp;
    logic [31:0] held = '0;
    logic stall_prev = 1'b0;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    while (got < 200 && cyc < 4000) begin
      in_valid  = (sent < 200) && ($urandom_range(0, 1) == 1);
      in_data   = 32'h5000 + 32'(sent);
      out_ready = ($urandom_range(0, 2) != 0);
      #2;
      tests++;
      if (fifo_cnt !== 4'(q.size())) begin
        fails++;
        $display("FAIL rand_cnt got %0d want %0d", fifo_cnt, q.size());
      end
      if (stall_prev) begin
        tests++;
        if ({out_valid, out_data} !== {1'b1, held}) begin
          fails++;
          $display("FAIL rand_stall got %b/%h want 1/%h",
                   out_valid, out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        exp = (q.size() > 0) ? q.pop_front() : 32'hBAD0BAD0;
        tests++;
        if (out_data !== exp) begin
          fails++;
          $display("FAIL rand_data got %h want %h", out_data, exp);
        end
        got++;
      end
      stall_prev = out_valid && !out_ready;
      held       = out_data;
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      nxt();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (got != 200) begin
      fails++;
      $display("FAIL rand_count got %0d want 200", got);
    end
  endtask

  task automatic test_full_boundary();
    logic [31:0] exp_q[$];
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h31 + 32'(k);
      nxt();
    end
    in_data   = 32'h77;
    out_ready = 1'b1;
    #2;
    tests++;
    if ({in_ready, ram_rd_en, ram_wr_en} !== 3'b010) begin
      fails++;
      $display("FAIL full_same_cycle got rdy/rd/wr %b%b%b want 010",
               in_ready, ram_rd_en, ram_wr_en);
    end
    nxt();
    out_ready = 1'b0;
    #2;
    tests++;
    if ({in_ready, ram_wr_en} !== 2'b11) begin
      fails++;
      $display("FAIL full_next_accept got rdy/wr %b%b want 11",
               in_ready, ram_wr_en);
    end
    nxt();
    in_valid = 1'b0;
    for (int k = 1; k < 10; k++) exp_q.push_back(32'h31 + 32'(k));
    exp_q.push_back(32'h77);
    out_ready = 1'b1;
    foreach (exp_q[i]) begin
      #2;
      tests++;
      if ({out_valid, out_data} !== {1'b1, exp_q[i]}) begin
        fails++;
        $display("FAIL full_drain_%0d got %b/%h want 1/%h",
                 i, out_valid, out_data, exp_q[i]);
      end
      nxt();
    end
    #2;
    tests++;
    if ({out_valid, fifo_cnt} !== {1'b0, 4'd0}) begin
      fails++;
      $display("FAIL full_end got %b/%0d want 0/0", out_valid, fifo_cnt);
    end
    out_ready = 1'b0;
    nxt();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h61 + 32'(k);
      nxt();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2;
    tests++;
    if (ram_rd_en !== 1'b1) begin
      fails++;
      $display("FAIL rmid_read_issue got %b want 1", ram_rd_en);
    end
    nxt();
    out_ready = 1'b0;
    #2;
    tests++;
    if (fifo_cnt !== 4'd4) begin
      fails++;
      $display("FAIL rmid_pre_cnt got %0d want 4", fifo_cnt);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, fifo_cnt} !== {1'b0, 4'd0}) begin
      fails++;
      $display("FAIL rmid_async got %b/%0d want 0/0", out_valid, fifo_cnt);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    nxt();
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    #2;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_accept got %b want 1", in_ready);
    end
    nxt();
    in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      #2;
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL rmid_early_%0d got %b want 0", k, out_valid);
      end
      nxt();
    end
    #2;
    tests++;
    if ({out_valid, out_data} !== {1'b1, 32'hDEAD}) begin
      fails++;
      $display("FAIL rmid_first got %b/%h want 1/dead", out_valid, out_data);
    end
    tests++;
    if (fifo_cnt !== 4'd1) begin
      fails++;
      $display("FAIL rmid_cnt got %0d want 1", fifo_cnt);
    end
    nxt();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_random();
    test_full_boundary();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
